udma_tx_chan_server: RTL and testbench
======================================

Name: udma_tx_chan_server

Overview:
- Single-channel uDMA TX channel server. It is the L2-facing end of a peripheral's req/gnt/valid/ready TX data interface.
- Owns the TX transfer descriptor: start address, size, continuous flag, and one queued (pending) descriptor.
- Issues L2 reads on behalf of the peripheral and returns lane-aligned data to it.
- Sits in the uDMA core between the L2 read port and one peripheral TX port, for example a UART TX FIFO.

Parameters:
- L2_AWIDTH_NOAL, 12: byte address width of L2 and descriptor addresses.
- TRANS_SIZE, 16: width of the transfer size and bytes-left counter.

Ports:
- sys_clk_i  in  1  system clock
- rstn_i  in  1  asynchronous active-low reset
- cfg_startaddr_i  in  L2_AWIDTH_NOAL  descriptor start byte address
- cfg_size_i  in  TRANS_SIZE  descriptor size in bytes
- cfg_continuous_i  in  1  reload the descriptor at end of transfer
- cfg_en_i  in  1  single-cycle pulse: launch or queue a descriptor
- cfg_clr_i  in  1  single-cycle pulse: abort the channel
- cfg_en_o  out  1  channel active
- cfg_pending_o  out  1  queued descriptor held
- cfg_curr_addr_o  out  L2_AWIDTH_NOAL  next read address
- cfg_bytes_left_o  out  TRANS_SIZE  bytes remaining
- end_event_o  out  1  one-cycle pulse at end of transfer
- ch_req_i  in  1  peripheral requests one element
- ch_gnt_o  out  1  request accepted
- ch_datasize_i  in  2  element size: 00=1 byte, 01=2 bytes, 1x=4 bytes
- ch_data_o  out  32  returned element, right-aligned, zero-extended
- ch_valid_o  out  1  ch_data_o valid
- ch_ready_i  in  1  peripheral accepts ch_data_o
- l2_req_o  out  1  L2 read request
- l2_gnt_i  in  1  L2 grant
- l2_addr_o  out  L2_AWIDTH_NOAL  byte address (L2 ignores bits [1:0])
- l2_rdata_i  in  32  L2 read word
- l2_rvalid_i  in  1  read data valid; arrives at least 1 cycle after the grant, in order

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; no read outstanding; output buffer empty; pending slot empty.
- FSM has two states, IDLE and ACTIVE. cfg_en_o = (state == ACTIVE).
- Launch and queue:
  - cfg_en_i in IDLE with cfg_size_i != 0: load address, bytes_left and continuous flag; go ACTIVE next cycle.
  - cfg_en_i in ACTIVE: store the descriptor in the pending slot; cfg_pending_o=1. A second cfg_en_i overwrites the slot.
  - cfg_size_i == 0: cfg_en_i is ignored.
- Stride = 1, 2 or 4 bytes, taken from ch_datasize_i.
- Request and grant:
  - l2_req_o = ch_req_i & ACTIVE & ~outstanding & ~ch_valid_o & ~cfg_clr_i. This is combinational.
  - l2_addr_o = cfg_curr_addr_o.
  - ch_gnt_o = l2_req_o & l2_gnt_i, in the same cycle.
  - At most one read is outstanding at a time.
- On a grant:
  - Set outstanding and latch addr[1:0] and the datasize.
  - curr_addr += stride, wrapping modulo 2^L2_AWIDTH_NOAL.
  - bytes_left -= stride. If bytes_left <= stride, bytes_left goes to 0 and end handling runs in the same edge.
- End handling, in priority order:
  1. Pending slot full: load the pending descriptor and clear cfg_pending_o.
  2. Continuous flag set: reload the original descriptor.
  3. Otherwise: go IDLE.
  - In all three cases end_event_o pulses 1 cycle after the final grant.
- Read return:
  - On l2_rvalid_i: ch_data_o = l2_rdata_i >> (8*latched addr[1:0]), masked to the latched size. ch_valid_o=1 and outstanding clears.
  - Min latency from grant to ch_valid_o is 2 cycles.
  - ch_valid_o holds with stable data until ch_ready_i is high.
  - Data from the final element of a transfer is still delivered after the FSM reaches IDLE.
- Clear (cfg_clr_i):
  - Effect next cycle: FSM to IDLE, bytes_left=0, pending slot cleared, output buffer dropped (ch_valid_o=0). No end_event_o.
  - A read already in flight completes on L2, but its data is discarded and not presented.
  - A new launch is blocked until outstanding clears.
  - cfg_clr_i has priority over a simultaneous cfg_en_i, which is dropped.
- Simultaneous cfg_en_i and the final grant while ACTIVE: the new descriptor is the one loaded at end (pending path). cfg_pending_o stays 0.
- Misaligned element crossing a word boundary (e.g. a 4-byte element at addr[1:0]!=0): upper lanes read 0. Software must avoid this case.

Test Plan:
- Byte stream: start=0x100, size=3, datasize=00, L2 word 0x44332211, peripheral always ready → ch_data_o 0x11, 0x22, 0x33. addr steps 0x100→0x103, bytes_left 3→0, one end_event_o, cfg_en_o falls.
- Halfword with lane shift: start=0x102, size=2, datasize=01, L2 word 0xAABBCCDD → one element 0x0000AABB, end_event_o.
- Pending queue: launch size=4 at 0x0, cfg_en_i at 0x40 size=4 mid-transfer → cfg_pending_o=1. After 4 bytes: addr=0x40, pending=0, one end pulse, channel stays active.
- Continuous: size=2, continuous=1, 5 byte requests → address sequence 0,1,0,1,0; end_event_o pulses after the 2nd and 4th grants.
- Abort: clr one cycle after a grant, rvalid arrives 2 cycles later → ch_valid_o stays 0, cfg_en_o=0, bytes_left=0, no end pulse.
- Backpressure and overshoot: ch_ready_i low 5 cycles → ch_valid_o and ch_data_o held, no new l2_req_o. size=3 with datasize=10 → one grant, bytes_left clamps to 0, end pulse.

Source files
------------

// File: rtl/udma_tx_chan_server_if.sv
// rtl/udma_tx_chan_server_if.sv - peripheral TX channel and L2 read port bundle
// slave is the channel server's view; master is the peripheral/L2 side.
interface udma_tx_chan_server_if #(
  parameter int AW = 12
);
  logic          ch_req_i;
  logic          ch_gnt_o;
  logic [1:0]    ch_datasize_i;
  logic [31:0]   ch_data_o;
  logic          ch_valid_o;
  logic          ch_ready_i;
  logic          l2_req_o;
  logic          l2_gnt_i;
  logic [AW-1:0] l2_addr_o;
  logic [31:0]   l2_rdata_i;
  logic          l2_rvalid_i;

  modport slave (
    input  ch_req_i, ch_datasize_i, ch_ready_i, l2_gnt_i, l2_rdata_i, l2_rvalid_i,
    output ch_gnt_o, ch_data_o, ch_valid_o, l2_req_o, l2_addr_o
  );

  modport master (
    output ch_req_i, ch_datasize_i, ch_ready_i, l2_gnt_i, l2_rdata_i, l2_rvalid_i,
    input  ch_gnt_o, ch_data_o, ch_valid_o, l2_req_o, l2_addr_o
  );
endinterface

// File: rtl/udma_tx_chan_server.sv
// rtl/udma_tx_chan_server.sv - uDMA TX channel server: descriptor, L2 reads, lane-aligned return
// One read in flight at a time; a queued descriptor is taken at end of transfer.
module udma_tx_chan_server #(
  parameter int L2_AWIDTH_NOAL = 12,
  parameter int TRANS_SIZE     = 16
) (
  input  logic                      sys_clk_i,
  input  logic                      rstn_i,
  input  logic [L2_AWIDTH_NOAL-1:0] cfg_startaddr_i,
  input  logic [TRANS_SIZE-1:0]     cfg_size_i,
  input  logic                      cfg_continuous_i,
  input  logic                      cfg_en_i,
  input  logic                      cfg_clr_i,
  output logic                      cfg_en_o,
  output logic                      cfg_pending_o,
  output logic [L2_AWIDTH_NOAL-1:0] cfg_curr_addr_o,
  output logic [TRANS_SIZE-1:0]     cfg_bytes_left_o,
  output logic                      end_event_o,
  udma_tx_chan_server_if.slave      bus
);

  typedef enum logic {IDLE, ACTIVE} state_t;
  state_t state, state_nxt;

  logic [L2_AWIDTH_NOAL-1:0] curr_addr, orig_addr, pend_addr;
  logic [TRANS_SIZE-1:0]     bytes_left, orig_size, pend_size;
  logic                      cont, pend_cont, pend_valid;
  logic                      outstanding, discard, out_valid, end_event;
  logic [31:0]               out_data, rdata_shift;
  logic [1:0]                lat_lane, lat_size;

  logic [2:0] stride;
  logic       l2_req, grant, last, en_ok, launch, take_new, end_xfer;

  always_comb begin
    state_nxt = state;
    stride    = 3'd4;
    l2_req    = 1'b0;
    grant     = 1'b0;
    last      = 1'b0;
    en_ok     = 1'b0;
    launch    = 1'b0;
    take_new  = 1'b0;
    end_xfer  = 1'b0;

    case (bus.ch_datasize_i)
      2'b00:   stride = 3'd1;
      2'b01:   stride = 3'd2;
      default: stride = 3'd4;
    endcase

    l2_req   = bus.ch_req_i & (state == ACTIVE) & ~outstanding & ~out_valid & ~cfg_clr_i;
    grant    = l2_req & bus.l2_gnt_i;
    last     = bytes_left <= TRANS_SIZE'(stride);
    end_xfer = grant & last;
    en_ok    = cfg_en_i & (cfg_size_i != '0) & ~cfg_clr_i;
    // A discarded read must drain before a new descriptor may start.
    launch   = en_ok & (state == IDLE) & ~(outstanding & discard);
    take_new = en_ok & (state == ACTIVE);

    if (cfg_clr_i)
      state_nxt = IDLE;
    else if (state == IDLE && launch)
      state_nxt = ACTIVE;
    else if (end_xfer && !(take_new || pend_valid || cont))
      state_nxt = IDLE;
  end

  always_ff @(posedge sys_clk_i or negedge rstn_i) begin
    if (!rstn_i)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  assign rdata_shift = bus.l2_rdata_i >> {lat_lane, 3'b000};

  always_ff @(posedge sys_clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      curr_addr   <= '0;
      orig_addr   <= '0;
      pend_addr   <= '0;
      bytes_left  <= '0;
      orig_size   <= '0;
      pend_size   <= '0;
      cont        <= 1'b0;
      pend_cont   <= 1'b0;
      pend_valid  <= 1'b0;
      outstanding <= 1'b0;
      discard     <= 1'b0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      end_event   <= 1'b0;
      lat_lane    <= '0;
      lat_size    <= '0;
    end else begin
      end_event <= end_xfer;
      if (cfg_clr_i) begin
        bytes_left <= '0;
        pend_valid <= 1'b0;
        out_valid  <= 1'b0;
        discard    <= outstanding & ~bus.l2_rvalid_i;
        if (bus.l2_rvalid_i)
          outstanding <= 1'b0;
      end else begin
        if (launch) begin
          curr_addr  <= cfg_startaddr_i;
          orig_addr  <= cfg_startaddr_i;
          bytes_left <= cfg_size_i;
          orig_size  <= cfg_size_i;
          cont       <= cfg_continuous_i;
        end
        if (take_new && !end_xfer) begin
          pend_addr  <= cfg_startaddr_i;
          pend_size  <= cfg_size_i;
          pend_cont  <= cfg_continuous_i;
          pend_valid <= 1'b1;
        end
        if (grant) begin
          outstanding <= 1'b1;
          lat_lane    <= curr_addr[1:0];
          lat_size    <= bus.ch_datasize_i;
          curr_addr   <= curr_addr + L2_AWIDTH_NOAL'(stride);
          bytes_left  <= last ? '0 : bytes_left - TRANS_SIZE'(stride);
          // A cfg_en_i coinciding with the final grant behaves as a pending slot write.
          if (last) begin
            pend_valid <= 1'b0;
            if (take_new) begin
              curr_addr  <= cfg_startaddr_i;
              orig_addr  <= cfg_startaddr_i;
              bytes_left <= cfg_size_i;
              orig_size  <= cfg_size_i;
              cont       <= cfg_continuous_i;
            end else if (pend_valid) begin
              curr_addr  <= pend_addr;
              orig_addr  <= pend_addr;
              bytes_left <= pend_size;
              orig_size  <= pend_size;
              cont       <= pend_cont;
            end else if (cont) begin
              curr_addr  <= orig_addr;
              bytes_left <= orig_size;
            end
          end
        end
        if (bus.l2_rvalid_i && outstanding) begin
          outstanding <= 1'b0;
          if (discard) begin
            discard <= 1'b0;
          end else begin
            out_valid <= 1'b1;
            case (lat_size)
              2'b00:   out_data <= {24'd0, rdata_shift[7:0]};
              2'b01:   out_data <= {16'd0, rdata_shift[15:0]};
              default: out_data <= rdata_shift;
            endcase
          end
        end else if (out_valid && bus.ch_ready_i) begin
          out_valid <= 1'b0;
        end
      end
    end
  end

  assign cfg_en_o         = (state == ACTIVE);
  assign cfg_pending_o    = pend_valid;
  assign cfg_curr_addr_o  = curr_addr;
  assign cfg_bytes_left_o = bytes_left;
  assign end_event_o      = end_event;
  assign bus.l2_req_o     = l2_req;
  assign bus.l2_addr_o    = curr_addr;
  assign bus.ch_gnt_o     = grant;
  assign bus.ch_valid_o   = out_valid;
  assign bus.ch_data_o    = out_data;

endmodule

// File: tb/tb_udma_tx_chan_server.sv
// tb/tb_udma_tx_chan_server.sv - directed self-checking bench for udma_tx_chan_server
module tb_udma_tx_chan_server;
  localparam int AW = 12;
  localparam int TS = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] cfg_startaddr = '0;
  logic [TS-1:0] cfg_size = '0;
  logic          cfg_cont = 1'b0;
  logic          cfg_en = 1'b0;
  logic          cfg_clr = 1'b0;
  logic          en_out, pending, end_event;
  logic [AW-1:0] curr_addr;
  logic [TS-1:0] bytes_left;

  int            n_checks = 0;
  int            n_errs = 0;
  int            end_cnt = 0;
  int            valid_cnt = 0;
  int            rlat = 1;
  int            e0, v0;
  logic [31:0]   l2_word = 32'h0;

  always #5 clk = ~clk;

  udma_tx_chan_server_if #(.AW(AW)) bus ();

  assign bus.l2_gnt_i = bus.l2_req_o;

  udma_tx_chan_server #(.L2_AWIDTH_NOAL(AW), .TRANS_SIZE(TS)) dut (
    .sys_clk_i        (clk),
    .rstn_i           (rst_n),
    .cfg_startaddr_i  (cfg_startaddr),
    .cfg_size_i       (cfg_size),
    .cfg_continuous_i (cfg_cont),
    .cfg_en_i         (cfg_en),
    .cfg_clr_i        (cfg_clr),
    .cfg_en_o         (en_out),
    .cfg_pending_o    (pending),
    .cfg_curr_addr_o  (curr_addr),
    .cfg_bytes_left_o (bytes_left),
    .end_event_o      (end_event),
    .bus              (bus.slave)
  );

  always @(negedge clk) begin
    if (end_event) end_cnt++;
    if (bus.ch_valid_o) valid_cnt++;
  end

  // L2 responder: one word per grant, returned rlat cycles after the grant edge.
  initial begin
    bus.l2_rvalid_i = 1'b0;
    bus.l2_rdata_i  = '0;
    forever begin
      @(negedge clk);
      if (bus.l2_req_o && bus.l2_gnt_i) begin
        @(posedge clk);
        repeat (rlat - 1) @(posedge clk);
        #1;
        bus.l2_rvalid_i = 1'b1;
        bus.l2_rdata_i  = l2_word;
        @(posedge clk);
        #1;
        bus.l2_rvalid_i = 1'b0;
        bus.l2_rdata_i  = '0;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [AW-1:0] a, input logic [TS-1:0] s, input logic c);
    cfg_startaddr = a;
    cfg_size      = s;
    cfg_cont      = c;
    cfg_en        = 1'b1;
    tick();
    cfg_en        = 1'b0;
  endtask

  task automatic clear();
    cfg_clr = 1'b1;
    tick();
    cfg_clr = 1'b0;
  endtask

  task automatic wait_gnt(input string tag, input logic [AW-1:0] exp_addr);
    bit got = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.ch_gnt_o) begin
        got = 1;
        check({tag, "_addr"}, 32'(bus.l2_addr_o), 32'(exp_addr));
      end
      tick();
      if (got) break;
    end
    if (!got) check({tag, "_gnt_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic wait_valid(input string tag, input logic [31:0] exp_data);
    bit got = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.ch_valid_o) begin
        got = 1;
        check({tag, "_data"}, bus.ch_data_o, exp_data);
      end
      tick();
      if (got) break;
    end
    if (!got) check({tag, "_valid_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic xfer(input logic [1:0] ds, input logic [31:0] exp_data,
                      input logic [AW-1:0] exp_addr, input string tag);
    bus.ch_datasize_i = ds;
    bus.ch_req_i      = 1'b1;
    wait_gnt(tag, exp_addr);
    bus.ch_req_i      = 1'b0;
    wait_valid(tag, exp_data);
  endtask

  initial begin
    bus.ch_req_i      = 1'b0;
    bus.ch_datasize_i = 2'b00;
    bus.ch_ready_i    = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_en", 32'(en_out), 0);
    check("rst_pending", 32'(pending), 0);
    check("rst_addr", 32'(curr_addr), 0);
    check("rst_bytes_left", 32'(bytes_left), 0);
    check("rst_end", 32'(end_event), 0);
    check("rst_valid", 32'(bus.ch_valid_o), 0);
    check("rst_data", bus.ch_data_o, 0);
    check("rst_l2_req", 32'(bus.l2_req_o), 0);
    rst_n = 1'b1;
    tick();

    // Byte stream
    l2_word = 32'h44332211;
    e0 = end_cnt;
    launch(12'h100, 16'd3, 1'b0);
    check("b_en", 32'(en_out), 1);
    check("b_addr0", 32'(curr_addr), 32'h100);
    check("b_left0", 32'(bytes_left), 3);
    xfer(2'b00, 32'h11, 12'h100, "b0");
    check("b_left1", 32'(bytes_left), 2);
    xfer(2'b00, 32'h22, 12'h101, "b1");
    xfer(2'b00, 32'h33, 12'h102, "b2");
    check("b_end", 32'(end_cnt - e0), 1);
    check("b_en_fall", 32'(en_out), 0);
    check("b_addr_end", 32'(curr_addr), 32'h103);
    check("b_left_end", 32'(bytes_left), 0);

    // Halfword with lane shift
    l2_word = 32'hAABBCCDD;
    e0 = end_cnt;
    launch(12'h102, 16'd2, 1'b0);
    xfer(2'b01, 32'h0000AABB, 12'h102, "h0");
    check("h_end", 32'(end_cnt - e0), 1);
    check("h_en", 32'(en_out), 0);
    check("h_addr", 32'(curr_addr), 32'h104);

    // Pending queue
    l2_word = 32'h44332211;
    e0 = end_cnt;
    launch(12'h000, 16'd4, 1'b0);
    xfer(2'b00, 32'h11, 12'h000, "p0");
    launch(12'h040, 16'd4, 1'b0);
    check("p_pending", 32'(pending), 1);
    check("p_en_mid", 32'(en_out), 1);
    xfer(2'b00, 32'h22, 12'h001, "p1");
    xfer(2'b00, 32'h33, 12'h002, "p2");
    xfer(2'b00, 32'h44, 12'h003, "p3");
    check("p_addr", 32'(curr_addr), 32'h040);
    check("p_pending_clr", 32'(pending), 0);
    check("p_end", 32'(end_cnt - e0), 1);
    check("p_en", 32'(en_out), 1);
    check("p_left", 32'(bytes_left), 4);
    clear();
    check("p_clr_en", 32'(en_out), 0);
    check("p_clr_left", 32'(bytes_left), 0);

    // Continuous reload
    e0 = end_cnt;
    launch(12'h000, 16'd2, 1'b1);
    xfer(2'b00, 32'h11, 12'h000, "c0");
    xfer(2'b00, 32'h22, 12'h001, "c1");
    check("c_end2", 32'(end_cnt - e0), 1);
    xfer(2'b00, 32'h11, 12'h000, "c2");
    xfer(2'b00, 32'h22, 12'h001, "c3");
    check("c_end4", 32'(end_cnt - e0), 2);
    xfer(2'b00, 32'h11, 12'h000, "c4");
    check("c_end5", 32'(end_cnt - e0), 2);
    check("c_addr", 32'(curr_addr), 1);
    check("c_left", 32'(bytes_left), 1);
    check("c_en", 32'(en_out), 1);
    clear();

    // Zero-size launch is ignored
    launch(12'h050, 16'd0, 1'b0);
    check("z_en", 32'(en_out), 0);

    // Abort with a read in flight
    rlat = 3;
    e0 = end_cnt;
    v0 = valid_cnt;
    launch(12'h200, 16'd4, 1'b0);
    bus.ch_datasize_i = 2'b00;
    bus.ch_req_i      = 1'b1;
    wait_gnt("a0", 12'h200);
    bus.ch_req_i      = 1'b0;
    clear();
    check("a_en", 32'(en_out), 0);
    check("a_left", 32'(bytes_left), 0);
    launch(12'h200, 16'd4, 1'b0);
    check("a_blocked", 32'(en_out), 0);
    repeat (6) tick();
    check("a_no_valid", 32'(valid_cnt - v0), 0);
    check("a_no_end", 32'(end_cnt - e0), 0);
    launch(12'h200, 16'd4, 1'b0);
    check("a_relaunch", 32'(en_out), 1);
    clear();
    rlat = 1;

    // Backpressure
    l2_word = 32'h44332211;
    launch(12'h300, 16'd8, 1'b0);
    bus.ch_ready_i    = 1'b0;
    bus.ch_datasize_i = 2'b00;
    bus.ch_req_i      = 1'b1;
    wait_gnt("bp", 12'h300);
    wait_valid("bp", 32'h11);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_valid_hold", 32'(bus.ch_valid_o), 1);
      check("bp_data_hold", bus.ch_data_o, 32'h11);
      check("bp_no_req", 32'(bus.l2_req_o), 0);
      tick();
    end
    bus.ch_ready_i = 1'b1;
    bus.ch_req_i   = 1'b0;
    tick();
    check("bp_valid_drop", 32'(bus.ch_valid_o), 0);
    check("bp_left", 32'(bytes_left), 7);
    clear();

    // Overshoot: 4-byte element on a 3-byte transfer
    l2_word = 32'hDEADBEEF;
    e0 = end_cnt;
    launch(12'h010, 16'd3, 1'b0);
    xfer(2'b10, 32'hDEADBEEF, 12'h010, "ov");
    check("ov_left", 32'(bytes_left), 0);
    check("ov_end", 32'(end_cnt - e0), 1);
    check("ov_en", 32'(en_out), 0);
    check("ov_addr", 32'(curr_addr), 32'h014);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end
endmodule
